control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Timing SHALL be one clock; reset is asynchronous and active-high.
REQ-002 clk  input  1  rising-edge clock, shared with the datapath.
REQ-003 reset  input  1  asynchronous, active-high.
REQ-004 ir  input  32  current instruction register contents; opcode is ir[31:27].
REQ-005 con  input  1  branch condition flop output from the datapath.
REQ-006 stop  input  1  level request to halt at the next instruction boundary.
REQ-007 gra, grb, grc, r_in, r_out, ba_out  output  1 each  GPR select/encode strobes.
REQ-008 hi_in, lo_in, pc_in, ir_in, z_in, y_in, mar_in, mdr_in, outport_in, con_in  output  1 each  register load enables.
REQ-009 hi_out, lo_out, pc_out, z_high_out, z_low_out, mdr_out, inport_out, c_out  output  1 each  bus source selects; at most one (including r_out) high per cycle.
REQ-010 read, write, inc_pc  output  1 each  MDR source select, RAM write enable, ALU A-input constant-1 select.
REQ-011 alu_op  output  4  ALU operation code.
REQ-012 run  output  1  high while sequencing; low in HALT.

Function
REQ-013 States SHALL be: T0, T1, T2, T3, EXEC (step counter 0..5), HALT.
REQ-014 T0: pc_out, mar_in, inc_pc, z_in, alu_op=ALU_ADD.
REQ-015 T1: z_low_out, pc_in (memory wait cycle).
REQ-016 T2: read, mdr_in.
REQ-017 T3: mdr_out, ir_in; next state EXEC with step=0.
REQ-018 Every instruction whose address is loaded into MAR SHALL have exactly one idle cycle before read/mdr_in (synchronous RAM latency).
REQ-019 Reg-reg ALU ops: step0 grb r_out y_in; step1 grc r_out z_in with alu_op from opcode; step2 z_low_out gra r_in. Total 7 cycles.
REQ-020 Immediate ALU ops: same as REQ-019 with c_out replacing grc r_out in step1.
REQ-021 ld: step0 grb r_out ba_out y_in; step1 c_out ALU_ADD z_in; step2 z_low_out mar_in; step3 wait; step4 read mdr_in; step5 mdr_out gra r_in. Total 10 cycles.
REQ-022 ldi: steps 0-2 of ld, with step2 z_low_out gra r_in. Total 7 cycles.
REQ-023 st: steps 0-2 as ld; step3 gra r_out mdr_in (read low); step4 write. Total 9 cycles.
REQ-024 br: step0 gra r_out con_in; step1 pc_out y_in; step2 c_out ALU_ADD z_in; step3 z_low_out pc_in only if con=1. Total 8 cycles.
REQ-025 jr: step0 gra r_out pc_in.
REQ-026 jal: step0 pc_out r_in with R15 forced; step1 gra r_out pc_in.
REQ-027 in: step0 inport_out gra r_in.
REQ-028 out: step0 gra r_out outport_in.
REQ-029 mfhi/mflo: step0 hi_out or lo_out, gra r_in.
REQ-030 nop and undefined opcodes: step0 only, no strobes.
REQ-031 halt opcode: enter HALT.
REQ-032 After the last step of any instruction, next state SHALL be T0, or HALT if stop=1 at that edge.
REQ-033 HALT SHALL assert no strobes and hold run=0 until reset.
REQ-034 All outputs SHALL be Moore outputs decoded from state, step and registered ir; no combinational path from con or stop to outputs, except the REQ-024 step3 con gating.

Reset
REQ-035 While reset=1: state=T0, step=0, all strobes 0, alu_op=0, run=1 at release.
REQ-036 Reset asserted mid-instruction SHALL abandon it; there SHALL be no partial write pulse beyond the reset edge.

Configuration
REQ-037 Macro CTRL_MULDIV_EN defined: mul/div SHALL run step0 gra r_out y_in; step1 grb r_out z_in (ALU_MUL/ALU_DIV); step2 z_low_out lo_in; step3 z_high_out hi_in.
REQ-038 Macro CTRL_MULDIV_EN undefined: mul/div SHALL decode as nop (REQ-030).

Structure
REQ-039 Opcode constants, ALU_* codes and the state enum SHALL live in a shared package (ctrl_pkg) used by both datapath and sequencer.
REQ-040 One sub-module SHALL be used: ctrl_decode, combinational opcode-to-instruction-class decode.

Verification
REQ-041 Reset, then ir=add R1,R2,R3 (opcode 00011): cycles 4-6 show grb/y_in, grc/z_in alu_op=ALU_ADD, z_low_out/gra/r_in; T0 recurs at cycle 7.
REQ-042 ld R1,0x10(R2): mar_in at step2, no read at step3, read+mdr_in at step4, gra r_in at step5.
REQ-043 br with con=0 vs con=1: pc_in absent vs present at step3; all other strobes identical.
REQ-044 st: write high for exactly one cycle, at step4; mdr_in at step3 with read=0.
REQ-045 stop raised mid-instruction: the instruction completes, then HALT with run=0; reset asserted at step1 of an add: all strobes 0 next cycle, restart at T0.
REQ-046 Every cycle of a randomized opcode stream: one-hot check on bus source selects; mul with CTRL_MULDIV_EN undefined produces no strobes.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ctrl_pkg -- definitions shared by the datapath and the control sequencer.
//
// Contents:
//   OP_*        5-bit opcodes found in ir[31:27]
//   ALU_*       4-bit ALU operation codes driven on alu_op
//   ST_*        sequencer state encodings
//   instr_cls_t instruction classes produced by ctrl_decode
//   ctrl_out_t  bundle of every strobe the sequencer drives
//   last_step() final EXEC step index for each instruction class
package ctrl_pkg;

    // Opcodes
    localparam logic [4:0] OP_LD   = 5'd0;
    localparam logic [4:0] OP_LDI  = 5'd1;
    localparam logic [4:0] OP_ST   = 5'd2;
    localparam logic [4:0] OP_ADD  = 5'd3;
    localparam logic [4:0] OP_SUB  = 5'd4;
    localparam logic [4:0] OP_AND  = 5'd5;
    localparam logic [4:0] OP_OR   = 5'd6;
    localparam logic [4:0] OP_ROR  = 5'd7;
    localparam logic [4:0] OP_ROL  = 5'd8;
    localparam logic [4:0] OP_SHR  = 5'd9;
    localparam logic [4:0] OP_SHRA = 5'd10;
    localparam logic [4:0] OP_SHL  = 5'd11;
    localparam logic [4:0] OP_ADDI = 5'd12;
    localparam logic [4:0] OP_ANDI = 5'd13;
    localparam logic [4:0] OP_ORI  = 5'd14;
    localparam logic [4:0] OP_DIV  = 5'd15;
    localparam logic [4:0] OP_MUL  = 5'd16;
    localparam logic [4:0] OP_NEG  = 5'd17;
    localparam logic [4:0] OP_NOT  = 5'd18;
    localparam logic [4:0] OP_BR   = 5'd19;
    localparam logic [4:0] OP_JR   = 5'd20;
    localparam logic [4:0] OP_JAL  = 5'd21;
    localparam logic [4:0] OP_IN   = 5'd22;
    localparam logic [4:0] OP_OUT  = 5'd23;
    localparam logic [4:0] OP_MFHI = 5'd24;
    localparam logic [4:0] OP_MFLO = 5'd25;
    localparam logic [4:0] OP_NOP  = 5'd26;
    localparam logic [4:0] OP_HALT = 5'd27;

    // ALU operation codes (0 is the idle code driven outside ALU cycles)
    localparam logic [3:0] ALU_NOP  = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_ROR  = 4'd5;
    localparam logic [3:0] ALU_ROL  = 4'd6;
    localparam logic [3:0] ALU_SHR  = 4'd7;
    localparam logic [3:0] ALU_SHRA = 4'd8;
    localparam logic [3:0] ALU_SHL  = 4'd9;
    localparam logic [3:0] ALU_MUL  = 4'd10;
    localparam logic [3:0] ALU_DIV  = 4'd11;
    localparam logic [3:0] ALU_NEG  = 4'd12;
    localparam logic [3:0] ALU_NOT  = 4'd13;

    // Sequencer states
    localparam logic [2:0] ST_T0   = 3'd0;
    localparam logic [2:0] ST_T1   = 3'd1;
    localparam logic [2:0] ST_T2   = 3'd2;
    localparam logic [2:0] ST_T3   = 3'd3;
    localparam logic [2:0] ST_EXEC = 3'd4;
    localparam logic [2:0] ST_HALT = 3'd5;

    typedef enum logic [3:0] {
        CLS_NOP,
        CLS_ALU_RR,
        CLS_ALU_IMM,
        CLS_LD,
        CLS_LDI,
        CLS_ST,
        CLS_BR,
        CLS_JR,
        CLS_JAL,
        CLS_IN,
        CLS_OUT,
        CLS_MFHI,
        CLS_MFLO,
        CLS_MULDIV,
        CLS_HALT
    } instr_cls_t;

    typedef struct packed {
        logic       gra;
        logic       grb;
        logic       grc;
        logic       r_in;
        logic       r_out;
        logic       ba_out;
        logic       hi_in;
        logic       lo_in;
        logic       pc_in;
        logic       ir_in;
        logic       z_in;
        logic       y_in;
        logic       mar_in;
        logic       mdr_in;
        logic       outport_in;
        logic       con_in;
        logic       hi_out;
        logic       lo_out;
        logic       pc_out;
        logic       z_high_out;
        logic       z_low_out;
        logic       mdr_out;
        logic       inport_out;
        logic       c_out;
        logic       read;
        logic       write;
        logic       inc_pc;
        logic [3:0] alu_op;
    } ctrl_out_t;

    function automatic logic [2:0] last_step(input instr_cls_t cls);
        logic [2:0] s;
        case (cls)
            CLS_ALU_RR:  s = 3'd2;
            CLS_ALU_IMM: s = 3'd2;
            CLS_LD:      s = 3'd5;
            CLS_LDI:     s = 3'd2;
            CLS_ST:      s = 3'd4;
            CLS_BR:      s = 3'd3;
            CLS_JAL:     s = 3'd1;
            CLS_MULDIV:  s = 3'd3;
            default:     s = 3'd0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode -- combinational opcode to instruction-class decode.
//
// Ports:
//   opcode_i  [4:0]  ir[31:27]
//   cls_o            instruction class steering the EXEC steps
//   alu_op_o  [3:0]  ALU code used in the class's ALU step
//
// Configuration: CTRL_MULDIV_EN -- when defined, mul/div decode to the
// multi-step mul/div class; otherwise they fall to the nop class.
//
// neg and not are unary but share the reg-reg class; the ALU simply
// ignores its B operand for those codes.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [4:0] opcode_i,
    output instr_cls_t cls_o,
    output logic [3:0] alu_op_o
);

    always_comb begin
        cls_o    = CLS_NOP;
        alu_op_o = ALU_NOP;
        case (opcode_i)
            OP_LD:   cls_o = CLS_LD;
            OP_LDI:  cls_o = CLS_LDI;
            OP_ST:   cls_o = CLS_ST;
            OP_ADD:  begin cls_o = CLS_ALU_RR;  alu_op_o = ALU_ADD;  end
            OP_SUB:  begin cls_o = CLS_ALU_RR;  alu_op_o = ALU_SUB;  end
            OP_AND:  begin cls_o = CLS_ALU_RR;  alu_op_o = ALU_AND;  end
            OP_OR:   begin cls_o = CLS_ALU_RR;  alu_op_o = ALU_OR;   end
            OP_ROR:  begin cls_o = CLS_ALU_RR;  alu_op_o = ALU_ROR;  end
            OP_ROL:  begin cls_o = CLS_ALU_RR;  alu_op_o = ALU_ROL;  end
            OP_SHR:  begin cls_o = CLS_ALU_RR;  alu_op_o = ALU_SHR;  end
            OP_SHRA: begin cls_o = CLS_ALU_RR;  alu_op_o = ALU_SHRA; end
            OP_SHL:  begin cls_o = CLS_ALU_RR;  alu_op_o = ALU_SHL;  end
            OP_NEG:  begin cls_o = CLS_ALU_RR;  alu_op_o = ALU_NEG;  end
            OP_NOT:  begin cls_o = CLS_ALU_RR;  alu_op_o = ALU_NOT;  end
            OP_ADDI: begin cls_o = CLS_ALU_IMM; alu_op_o = ALU_ADD;  end
            OP_ANDI: begin cls_o = CLS_ALU_IMM; alu_op_o = ALU_AND;  end
            OP_ORI:  begin cls_o = CLS_ALU_IMM; alu_op_o = ALU_OR;   end
`ifdef CTRL_MULDIV_EN
            OP_MUL:  begin cls_o = CLS_MULDIV;  alu_op_o = ALU_MUL;  end
            OP_DIV:  begin cls_o = CLS_MULDIV;  alu_op_o = ALU_DIV;  end
`else
            // mul/div take the default nop class
`endif
            OP_BR:   cls_o = CLS_BR;
            OP_JR:   cls_o = CLS_JR;
            OP_JAL:  cls_o = CLS_JAL;
            OP_IN:   cls_o = CLS_IN;
            OP_OUT:  cls_o = CLS_OUT;
            OP_MFHI: cls_o = CLS_MFHI;
            OP_MFLO: cls_o = CLS_MFLO;
            OP_HALT: cls_o = CLS_HALT;
            default: cls_o = CLS_NOP;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer -- fetch/execute control unit for the single-bus CPU.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   ir [31:0]             datapath instruction register (opcode ir[31:27])
//   con                   branch condition flop from the datapath
//   stop                  halt request, sampled at instruction boundaries
//   gra..ba_out           GPR select/encode strobes
//   hi_in..con_in         register load enables
//   hi_out..c_out         bus source selects (one-hot with r_out)
//   read, write, inc_pc   MDR source, RAM write enable, ALU A = 1
//   alu_op [3:0]          ALU operation code
//   run                   low only in HALT
//
// Sequence: T0 T1 T2 T3 fetch, then EXEC steps 0..last_step(class), then
// T0 again (or HALT when stop is high at the final EXEC edge). T1 and EXEC
// idle steps cover the one-cycle synchronous RAM latency after mar_in.
//
// Handshake: none; the datapath follows the strobes unconditionally.
//
// All strobes are Moore outputs of state/step/ir, forced to zero while
// reset is high so an abandoned instruction cannot leave a write pulse.
// The only combinational input dependency is con gating pc_in in the
// branch's final step.
//
// jal writes the link register with r_in and no GPR select raised; the
// datapath's select/encode logic routes that case to R15.
//
// Configuration: CTRL_MULDIV_EN (see ctrl_decode) enables mul/div.
module control_sequencer
    import ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ir,
    input  logic        con,
    input  logic        stop,
    output logic        gra,
    output logic        grb,
    output logic        grc,
    output logic        r_in,
    output logic        r_out,
    output logic        ba_out,
    output logic        hi_in,
    output logic        lo_in,
    output logic        pc_in,
    output logic        ir_in,
    output logic        z_in,
    output logic        y_in,
    output logic        mar_in,
    output logic        mdr_in,
    output logic        outport_in,
    output logic        con_in,
    output logic        hi_out,
    output logic        lo_out,
    output logic        pc_out,
    output logic        z_high_out,
    output logic        z_low_out,
    output logic        mdr_out,
    output logic        inport_out,
    output logic        c_out,
    output logic        read,
    output logic        write,
    output logic        inc_pc,
    output logic [3:0]  alu_op,
    output logic        run
);

    logic [2:0] state_q, state_d;
    logic [2:0] step_q, step_d;
    instr_cls_t cls;
    logic [3:0] cls_alu;
    ctrl_out_t  dec;
    ctrl_out_t  drv;

    // Only the opcode field steers sequencing.
    logic unused_ir_bits;
    assign unused_ir_bits = ^ir[26:0];

    ctrl_decode u_decode (
        .opcode_i (ir[31:27]),
        .cls_o    (cls),
        .alu_op_o (cls_alu)
    );

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        case (state_q)
            ST_T0: state_d = ST_T1;
            ST_T1: state_d = ST_T2;
            ST_T2: state_d = ST_T3;
            ST_T3: begin
                state_d = ST_EXEC;
                step_d  = 3'd0;
            end
            ST_EXEC: begin
                if (step_q >= last_step(cls)) begin
                    step_d  = 3'd0;
                    state_d = (cls == CLS_HALT || stop) ? ST_HALT : ST_T0;
                end else begin
                    step_d  = step_q + 3'd1;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: begin
                state_d = ST_T0;
                step_d  = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_T0;
            step_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
        end
    end

    always_comb begin
        dec = '0;
        case (state_q)
            ST_T0: begin
                dec.pc_out = 1'b1;
                dec.mar_in = 1'b1;
                dec.inc_pc = 1'b1;
                dec.z_in   = 1'b1;
                dec.alu_op = ALU_ADD;
            end
            ST_T1: begin
                dec.z_low_out = 1'b1;
                dec.pc_in     = 1'b1;
            end
            ST_T2: begin
                dec.read   = 1'b1;
                dec.mdr_in = 1'b1;
            end
            ST_T3: begin
                dec.mdr_out = 1'b1;
                dec.ir_in   = 1'b1;
            end
            ST_EXEC: begin
                case (cls)
                    CLS_ALU_RR, CLS_ALU_IMM: begin
                        case (step_q)
                            3'd0: begin dec.grb = 1'b1; dec.r_out = 1'b1; dec.y_in = 1'b1; end
                            3'd1: begin
                                if (cls == CLS_ALU_IMM) begin
                                    dec.c_out = 1'b1;
                                end else begin
                                    dec.grc   = 1'b1;
                                    dec.r_out = 1'b1;
                                end
                                dec.z_in   = 1'b1;
                                dec.alu_op = cls_alu;
                            end
                            3'd2: begin dec.z_low_out = 1'b1; dec.gra = 1'b1; dec.r_in = 1'b1; end
                            default: ;
                        endcase
                    end
                    CLS_LD, CLS_LDI, CLS_ST: begin
                        // Shared effective-address steps: Z <= R[rb] + C.
                        case (step_q)
                            3'd0: begin
                                dec.grb = 1'b1; dec.r_out = 1'b1;
                                dec.ba_out = 1'b1; dec.y_in = 1'b1;
                            end
                            3'd1: begin dec.c_out = 1'b1; dec.z_in = 1'b1; dec.alu_op = ALU_ADD; end
                            3'd2: begin
                                dec.z_low_out = 1'b1;
                                if (cls == CLS_LDI) begin
                                    dec.gra  = 1'b1;
                                    dec.r_in = 1'b1;
                                end else begin
                                    dec.mar_in = 1'b1;
                                end
                            end
                            3'd3: begin
                                // ld idles here for RAM latency; st loads MDR from the bus.
                                if (cls == CLS_ST) begin
                                    dec.gra = 1'b1; dec.r_out = 1'b1; dec.mdr_in = 1'b1;
                                end
                            end
                            3'd4: begin
                                if (cls == CLS_ST) begin
                                    dec.write = 1'b1;
                                end else begin
                                    dec.read   = 1'b1;
                                    dec.mdr_in = 1'b1;
                                end
                            end
                            3'd5: begin dec.mdr_out = 1'b1; dec.gra = 1'b1; dec.r_in = 1'b1; end
                            default: ;
                        endcase
                    end
                    CLS_BR: begin
                        case (step_q)
                            3'd0: begin dec.gra = 1'b1; dec.r_out = 1'b1; dec.con_in = 1'b1; end
                            3'd1: begin dec.pc_out = 1'b1; dec.y_in = 1'b1; end
                            3'd2: begin dec.c_out = 1'b1; dec.z_in = 1'b1; dec.alu_op = ALU_ADD; end
                            3'd3: begin dec.z_low_out = 1'b1; dec.pc_in = con; end
                            default: ;
                        endcase
                    end
                    CLS_JR: begin
                        dec.gra = 1'b1; dec.r_out = 1'b1; dec.pc_in = 1'b1;
                    end
                    CLS_JAL: begin
                        if (step_q == 3'd0) begin
                            dec.pc_out = 1'b1; dec.r_in = 1'b1;
                        end else begin
                            dec.gra = 1'b1; dec.r_out = 1'b1; dec.pc_in = 1'b1;
                        end
                    end
                    CLS_IN:   begin dec.inport_out = 1'b1; dec.gra = 1'b1; dec.r_in = 1'b1; end
                    CLS_OUT:  begin dec.gra = 1'b1; dec.r_out = 1'b1; dec.outport_in = 1'b1; end
                    CLS_MFHI: begin dec.hi_out = 1'b1; dec.gra = 1'b1; dec.r_in = 1'b1; end
                    CLS_MFLO: begin dec.lo_out = 1'b1; dec.gra = 1'b1; dec.r_in = 1'b1; end
                    CLS_MULDIV: begin
                        case (step_q)
                            3'd0: begin dec.gra = 1'b1; dec.r_out = 1'b1; dec.y_in = 1'b1; end
                            3'd1: begin
                                dec.grb = 1'b1; dec.r_out = 1'b1;
                                dec.z_in = 1'b1; dec.alu_op = cls_alu;
                            end
                            3'd2: begin dec.z_low_out = 1'b1; dec.lo_in = 1'b1; end
                            3'd3: begin dec.z_high_out = 1'b1; dec.hi_in = 1'b1; end
                            default: ;
                        endcase
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign drv = reset ? '0 : dec;

    assign gra        = drv.gra;
    assign grb        = drv.grb;
    assign grc        = drv.grc;
    assign r_in       = drv.r_in;
    assign r_out      = drv.r_out;
    assign ba_out     = drv.ba_out;
    assign hi_in      = drv.hi_in;
    assign lo_in      = drv.lo_in;
    assign pc_in      = drv.pc_in;
    assign ir_in      = drv.ir_in;
    assign z_in       = drv.z_in;
    assign y_in       = drv.y_in;
    assign mar_in     = drv.mar_in;
    assign mdr_in     = drv.mdr_in;
    assign outport_in = drv.outport_in;
    assign con_in     = drv.con_in;
    assign hi_out     = drv.hi_out;
    assign lo_out     = drv.lo_out;
    assign pc_out     = drv.pc_out;
    assign z_high_out = drv.z_high_out;
    assign z_low_out  = drv.z_low_out;
    assign mdr_out    = drv.mdr_out;
    assign inport_out = drv.inport_out;
    assign c_out      = drv.c_out;
    assign read       = drv.read;
    assign write      = drv.write;
    assign inc_pc     = drv.inc_pc;
    assign alu_op     = drv.alu_op;
    assign run        = (state_q != ST_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer -- self-checking bench for control_sequencer.
// The bench plays the datapath: it presents each instruction word on ir
// from the cycle after ir_in, and predicts the full strobe vector of every
// cycle from a per-instruction script of named strobes.
module tb_control_sequencer;
  import ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  logic con;
  logic stop;
  logic [31:0] ir;

  always #5 clk = ~clk;

  logic gra, grb, grc, r_in, r_out, ba_out;
  logic hi_in, lo_in, pc_in, ir_in, z_in, y_in, mar_in, mdr_in, outport_in, con_in;
  logic hi_out, lo_out, pc_out, z_high_out, z_low_out, mdr_out, inport_out, c_out;
  logic read, write, inc_pc, run;
  logic [3:0] alu_op;

  control_sequencer dut (
    .clk(clk), .reset(reset), .ir(ir), .con(con), .stop(stop),
    .gra(gra), .grb(grb), .grc(grc), .r_in(r_in), .r_out(r_out), .ba_out(ba_out),
    .hi_in(hi_in), .lo_in(lo_in), .pc_in(pc_in), .ir_in(ir_in), .z_in(z_in),
    .y_in(y_in), .mar_in(mar_in), .mdr_in(mdr_in), .outport_in(outport_in),
    .con_in(con_in), .hi_out(hi_out), .lo_out(lo_out), .pc_out(pc_out),
    .z_high_out(z_high_out), .z_low_out(z_low_out), .mdr_out(mdr_out),
    .inport_out(inport_out), .c_out(c_out), .read(read), .write(write),
    .inc_pc(inc_pc), .alu_op(alu_op), .run(run)
  );

  // Observed vector: bit positions match the M_* masks below.
  logic [31:0] obs_vec;
  assign obs_vec = {run, alu_op, inc_pc, write, read, c_out, inport_out, mdr_out,
                    z_low_out, z_high_out, pc_out, lo_out, hi_out, con_in, outport_in,
                    mdr_in, mar_in, y_in, z_in, ir_in, pc_in, lo_in, hi_in, ba_out,
                    r_out, r_in, grc, grb, gra};

  localparam logic [31:0] M_GRA   = 32'd1 << 0;
  localparam logic [31:0] M_GRB   = 32'd1 << 1;
  localparam logic [31:0] M_GRC   = 32'd1 << 2;
  localparam logic [31:0] M_RIN   = 32'd1 << 3;
  localparam logic [31:0] M_ROUT  = 32'd1 << 4;
  localparam logic [31:0] M_BAOUT = 32'd1 << 5;
  localparam logic [31:0] M_HIIN  = 32'd1 << 6;
  localparam logic [31:0] M_LOIN  = 32'd1 << 7;
  localparam logic [31:0] M_PCIN  = 32'd1 << 8;
  localparam logic [31:0] M_IRIN  = 32'd1 << 9;
  localparam logic [31:0] M_ZIN   = 32'd1 << 10;
  localparam logic [31:0] M_YIN   = 32'd1 << 11;
  localparam logic [31:0] M_MARIN = 32'd1 << 12;
  localparam logic [31:0] M_MDRIN = 32'd1 << 13;
  localparam logic [31:0] M_OPIN  = 32'd1 << 14;
  localparam logic [31:0] M_CONIN = 32'd1 << 15;
  localparam logic [31:0] M_HIOUT = 32'd1 << 16;
  localparam logic [31:0] M_LOOUT = 32'd1 << 17;
  localparam logic [31:0] M_PCOUT = 32'd1 << 18;
  localparam logic [31:0] M_ZHOUT = 32'd1 << 19;
  localparam logic [31:0] M_ZLOUT = 32'd1 << 20;
  localparam logic [31:0] M_MDROUT= 32'd1 << 21;
  localparam logic [31:0] M_INPOUT= 32'd1 << 22;
  localparam logic [31:0] M_COUT  = 32'd1 << 23;
  localparam logic [31:0] M_READ  = 32'd1 << 24;
  localparam logic [31:0] M_WRITE = 32'd1 << 25;
  localparam logic [31:0] M_INCPC = 32'd1 << 26;
  localparam logic [31:0] M_RUN   = 32'd1 << 31;
  localparam logic [31:0] M_BUS   = M_ROUT | M_HIOUT | M_LOOUT | M_PCOUT | M_ZHOUT |
                                    M_ZLOUT | M_MDROUT | M_INPOUT | M_COUT;

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] alu(input logic [3:0] code);
    return {1'b0, code, 27'd0};
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [3:0] alu_of(input logic [4:0] op);
    case (op)
      OP_ADD, OP_ADDI: return ALU_ADD;
      OP_SUB:          return ALU_SUB;
      OP_AND, OP_ANDI: return ALU_AND;
      OP_OR, OP_ORI:   return ALU_OR;
      OP_ROR:          return ALU_ROR;
      OP_ROL:          return ALU_ROL;
      OP_SHR:          return ALU_SHR;
      OP_SHRA:         return ALU_SHRA;
      OP_SHL:          return ALU_SHL;
      OP_NEG:          return ALU_NEG;
      OP_NOT:          return ALU_NOT;
      OP_MUL:          return ALU_MUL;
      OP_DIV:          return ALU_DIV;
      default:         return ALU_NOP;
    endcase
  endfunction

  task automatic push_fetch();
    exp_q.push_back(M_RUN | M_PCOUT | M_MARIN | M_INCPC | M_ZIN | alu(ALU_ADD));
    exp_q.push_back(M_RUN | M_ZLOUT | M_PCIN);
    exp_q.push_back(M_RUN | M_READ | M_MDRIN);
    exp_q.push_back(M_RUN | M_MDROUT | M_IRIN);
  endtask

  task automatic push_exec(input logic [4:0] op, input logic conv);
    logic [31:0] r;
    r = M_RUN;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL, OP_NEG, OP_NOT: begin
        exp_q.push_back(r | M_GRB | M_ROUT | M_YIN);
        exp_q.push_back(r | M_GRC | M_ROUT | M_ZIN | alu(alu_of(op)));
        exp_q.push_back(r | M_ZLOUT | M_GRA | M_RIN);
      end
      OP_ADDI, OP_ANDI, OP_ORI: begin
        exp_q.push_back(r | M_GRB | M_ROUT | M_YIN);
        exp_q.push_back(r | M_COUT | M_ZIN | alu(alu_of(op)));
        exp_q.push_back(r | M_ZLOUT | M_GRA | M_RIN);
      end
      OP_LD, OP_LDI, OP_ST: begin
        exp_q.push_back(r | M_GRB | M_ROUT | M_BAOUT | M_YIN);
        exp_q.push_back(r | M_COUT | M_ZIN | alu(ALU_ADD));
        if (op == OP_LDI) begin
          exp_q.push_back(r | M_ZLOUT | M_GRA | M_RIN);
        end else begin
          exp_q.push_back(r | M_ZLOUT | M_MARIN);
          if (op == OP_LD) begin
            exp_q.push_back(r);
            exp_q.push_back(r | M_READ | M_MDRIN);
            exp_q.push_back(r | M_MDROUT | M_GRA | M_RIN);
          end else begin
            exp_q.push_back(r | M_GRA | M_ROUT | M_MDRIN);
            exp_q.push_back(r | M_WRITE);
          end
        end
      end
      OP_BR: begin
        exp_q.push_back(r | M_GRA | M_ROUT | M_CONIN);
        exp_q.push_back(r | M_PCOUT | M_YIN);
        exp_q.push_back(r | M_COUT | M_ZIN | alu(ALU_ADD));
        exp_q.push_back(r | M_ZLOUT | (conv ? M_PCIN : 32'd0));
      end
      OP_JR:   exp_q.push_back(r | M_GRA | M_ROUT | M_PCIN);
      OP_JAL: begin
        exp_q.push_back(r | M_PCOUT | M_RIN);
        exp_q.push_back(r | M_GRA | M_ROUT | M_PCIN);
      end
      OP_IN:   exp_q.push_back(r | M_INPOUT | M_GRA | M_RIN);
      OP_OUT:  exp_q.push_back(r | M_GRA | M_ROUT | M_OPIN);
      OP_MFHI: exp_q.push_back(r | M_HIOUT | M_GRA | M_RIN);
      OP_MFLO: exp_q.push_back(r | M_LOOUT | M_GRA | M_RIN);
`ifdef CTRL_MULDIV_EN
      OP_MUL, OP_DIV: begin
        exp_q.push_back(r | M_GRA | M_ROUT | M_YIN);
        exp_q.push_back(r | M_GRB | M_ROUT | M_ZIN | alu(alu_of(op)));
        exp_q.push_back(r | M_ZLOUT | M_LOIN);
        exp_q.push_back(r | M_ZHOUT | M_HIIN);
      end
`endif
      default: exp_q.push_back(r);  // nop, undefined, halt: one quiet step
    endcase
  endtask

  // ---------------- driver tasks ----------------
  // con_sel: -1 random, else forced branch condition.
  // stop_from: cycle index from which stop stays high (-1: random, low at end).
  // abort_at: cycle index where the task stops before checking (-1: never).
  task automatic run_instr(input logic [31:0] word, input int con_sel,
                           input int stop_from, input int abort_at);
    logic [4:0] op;
    logic conv;
    int n;
    op = word[31:27];
    conv = (con_sel < 0) ? 1'($urandom_range(0, 1)) : 1'(con_sel);
    push_fetch();
    push_exec(op, conv);
    n = exp_q.size();
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      con = (op == OP_BR) ? conv : 1'($urandom_range(0, 1));
      if (stop_from >= 0 && c >= stop_from) stop = 1'b1;
      else if (c == n - 1) stop = 1'b0;
      else stop = 1'($urandom_range(0, 1));
      if (c == 3) ir = word;
      if (c == abort_at) begin
        exp_q.delete();
        return;
      end
      #1;
      check_vec($sformatf("op%0d_c%0d", op, c), obs_vec, exp_q.pop_front());
      check_vec("bus_onehot", {31'd0, ($countones(obs_vec & M_BUS) <= 1)}, 32'd1);
    end
  endtask

  task automatic check_halt(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      con = 1'($urandom_range(0, 1));
      stop = 1'($urandom_range(0, 1));
      #1;
      check_vec("halt", obs_vec, 32'd0);
    end
  endtask

  // Holds reset across a clock edge, checks the quiet reset vector, then
  // releases away from the edge so the next cycle is T0.
  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #2;
    check_vec("reset_hold", obs_vec, M_RUN);
    reset = 1'b0;
    stop = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [4:0] rop;
    reset = 1'b1;
    con = 1'b0;
    stop = 1'b0;
    ir = 32'd0;
    @(posedge clk);
    do_reset();

    // add R1,R2,R3
    run_instr({OP_ADD, 4'd1, 4'd2, 4'd3, 15'd0}, -1, -1, -1);
    // ld R1,0x10(R2)
    run_instr({OP_LD, 4'd1, 4'd2, 19'h10}, -1, -1, -1);
    // br with con=0 then con=1
    run_instr({OP_BR, 4'd4, 4'd0, 19'h20}, 0, -1, -1);
    run_instr({OP_BR, 4'd4, 4'd0, 19'h20}, 1, -1, -1);
    // st, ldi, jal, mul
    run_instr({OP_ST, 4'd5, 4'd6, 19'h7}, -1, -1, -1);
    run_instr({OP_LDI, 4'd2, 4'd0, 19'h3}, -1, -1, -1);
    run_instr({OP_JAL, 4'd9, 23'd0}, -1, -1, -1);
    run_instr({OP_MUL, 4'd1, 4'd2, 19'd0}, -1, -1, -1);
    run_instr({OP_DIV, 4'd3, 4'd4, 19'd0}, -1, -1, -1);

    // randomized opcode stream (halt excluded)
    for (int i = 0; i < 150; i++) begin
      rop = 5'($urandom_range(0, 31));
      if (rop == OP_HALT) rop = OP_NOP;
      run_instr({rop, 27'($urandom)}, -1, -1, -1);
    end

    // stop raised mid-add: the add completes, then HALT
    run_instr({OP_ADD, 4'd1, 4'd2, 4'd3, 15'd0}, -1, 5, -1);
    check_halt(3);
    do_reset();

    // reset asserted at step1 of an add
    run_instr({OP_ADD, 4'd1, 4'd2, 4'd3, 15'd0}, -1, -1, 5);
    reset = 1'b1;
    #1;
    check_vec("reset_mid", obs_vec, M_RUN);
    do_reset();
    run_instr({OP_ADD, 4'd7, 4'd8, 4'd9, 15'd0}, -1, -1, -1);

    // halt opcode
    run_instr({OP_HALT, 27'd0}, -1, -1, -1);
    check_halt(4);

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
